awg_pattern_engine: RTL and testbench
=====================================

AWG_PATTERN_ENGINE -- requirements
Module: awg_pattern_engine

Interface
REQ-001 Parameters (name, default, meaning): NUM_SIG, 8, pattern width in bits; NUM_SAMP, 256, buffer depth in samples; DIV_W, 16, width of the divider and loop fields.
REQ-002 Ports (name, direction, width, meaning):
- axi_clk, in, 1: sole clock; reset axi_resetn, asynchronous, active-low.
- axi_resetn, in, 1: reset.
- run, in, 1: start pulse.
- abort, in, 1: stop pulse.
- clear, in, 1: empty the write buffer.
- clk_div, in, DIV_W: sample period minus 1, in axi_clk cycles.
- loop_count, in, DIV_W: extra passes after the first.
- write_channel, in, NUM_SIG: sample to append.
- write_channel_wrStrobe, in, 1: append strobe.
- read_channel_rdStrobe, in, 1: capture-read strobe.
- read_channel, out, NUM_SIG: captured sample.
- output_signals, out, NUM_SIG: pattern output.
- input_signals, in, NUM_SIG: capture input.
- sample_count, out, 32: ticks in the current or last run.
- write_buffer_len, out, 32: samples loaded.
- next_read_sample, out, 32: read pointer.
- status, out, 6: {overflow, aborted, done, busy, state[1:0]}.

Function
REQ-003 States SHALL be IDLE=0, RUN=1, DONE=2, WAIT_TRIG=3; WAIT_TRIG is reachable only with the macro defined.
REQ-004 The sample tick SHALL come from a divider counter that counts 0..clk_div and is cleared on run acceptance; tick fires when counter==clk_div, so clk_div=0 ticks every cycle.
REQ-005 run in IDLE with write_buffer_len>0 SHALL be accepted: go to RUN next cycle; clear wave_ptr, loop index, sample_count, done and aborted.
REQ-006 run with write_buffer_len==0, or run in any state other than IDLE, SHALL be ignored.
REQ-007 On each tick in RUN the block SHALL:
- register output_signals <= write_buffer[wave_ptr];
- write read_buffer[wave_ptr] <= input_signals;
- increment sample_count, saturating at 0xFFFFFFFF.
REQ-008 At a tick with wave_ptr==write_buffer_len-1:
- if loop index==loop_count, go to DONE;
- otherwise set wave_ptr to 0 and increment the loop index.
Each pass overwrites read_buffer, so read_buffer holds the final pass.
REQ-009 Between ticks, output_signals SHALL hold its value.
REQ-010 DONE SHALL last exactly 1 cycle: set done (sticky), set output_signals to 0, set next_read_sample to 0, then go to IDLE.
REQ-011 In IDLE and WAIT_TRIG, output_signals SHALL be 0.
REQ-012 abort in RUN or WAIT_TRIG SHALL give IDLE next cycle with output_signals 0, done unchanged and aborted set. abort SHALL win over a simultaneous run.
REQ-013 busy SHALL equal (state!=IDLE).
REQ-014 wrStrobe in IDLE with write_buffer_len<NUM_SAMP SHALL store write_channel at index write_buffer_len and increment write_buffer_len.
REQ-015 wrStrobe when the buffer is full SHALL be dropped and set overflow (sticky). wrStrobe while busy SHALL be dropped with no flag.
REQ-016 clear in IDLE SHALL zero write_buffer_len and overflow. clear SHALL win over a simultaneous wrStrobe and is ignored while busy.
REQ-017 rdStrobe in IDLE SHALL register read_channel <= read_buffer[next_read_sample] (valid the cycle after the strobe). The pointer increments, saturating at write_buffer_len; a strobe at saturation returns 0. rdStrobe while busy is ignored and read_channel holds.
REQ-018 write_buffer_len is retained after DONE, so a repeat run replays the same pattern.

Reset
REQ-019 While axi_resetn is low, the block SHALL immediately force:
- state=IDLE;
- all counters, pointers, flags, output_signals and read_channel to 0;
- buffer contents to 0.
REQ-020 Reset mid-RUN SHALL set output_signals to 0 asynchronously; there is no done pulse.

Configuration
REQ-021 With AWG_EXT_TRIG_EN defined:
- input ext_trig (1 bit) is added, with a 2-flop synchroniser;
- an accepted run enters WAIT_TRIG;
- the first synchronised rising edge enters RUN, with the divider cleared.
REQ-022 Without AWG_EXT_TRIG_EN, the ext_trig port and WAIT_TRIG logic SHALL be absent, and run enters RUN directly.

Structure
REQ-023 Package awg_pkg SHALL hold the state enum typedef, the status bit indices and the sample_count width constant.
REQ-024 The divider SHALL be a sub-module awg_tick_gen (ports: clk, resetn, clr, div, tick).

Verification
REQ-025 Basic run: load 4 samples 0x01,0x02,0x04,0x08; clk_div=0; loop_count=0; run.
- output_signals shows 01,02,04,08 on consecutive cycles, then 0.
- sample_count=4, done=1.
REQ-026 Divider and loops: same pattern, clk_div=2, loop_count=1.
- Each value holds 3 cycles; the sequence repeats twice.
- sample_count=8.
REQ-027 Capture readback: input_signals=wave_ptr^0xFF during the run, then 4 rdStrobes.
- read_channel returns FF,FE,FD,FC; a 5th strobe returns 00.
REQ-028 Overflow: NUM_SAMP+1 writes.
- write_buffer_len=NUM_SAMP, overflow=1.
- clear gives len=0 and overflow=0.
REQ-029 Abort: abort after 2 ticks.
- IDLE next cycle, outputs 0, aborted=1, done=0.
- Writes and run issued while busy are ignored.
REQ-030 With AWG_EXT_TRIG_EN: run, then hold ext_trig low for 20 cycles.
- State stays WAIT_TRIG with outputs 0.
- ext_trig rising puts the state in RUN 2-3 cycles later.

Source files
------------

// File: rtl/awg_pattern_engine_pkg.sv
// Shared definitions for the AWG pattern engine.
//   awg_state_e    : controller state encoding, also reported in status[1:0]
//   SAMPLE_CNT_W   : width of the sample_count output
//   STAT_*         : bit positions inside the 6-bit status word
package awg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_DONE      = 2'd2,
    ST_WAIT_TRIG = 2'd3
  } awg_state_e;

  localparam int unsigned SAMPLE_CNT_W = 32;

  localparam int unsigned STAT_OVF     = 5;
  localparam int unsigned STAT_ABORTED = 4;
  localparam int unsigned STAT_DONE    = 3;
  localparam int unsigned STAT_BUSY    = 2;

endpackage

// File: rtl/awg_pattern_engine_tick_gen.sv
// Sample-rate divider for the AWG pattern engine.
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : restart the count from 0 (suppresses tick this cycle)
//   div         : period minus 1; counter runs 0..div
//   tick        : high in the cycle where the counter equals div
module awg_tick_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = !clr && (cnt_q == div);

  // >= rather than == so a div lowered below the current count still wraps
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q >= div)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/awg_pattern_engine.sv
// AWG pattern engine: plays a loaded sample buffer on output_signals at a
// divided sample rate, optionally looping, while capturing input_signals
// into a read buffer that can be drained afterwards.
//   axi_clk/axi_resetn        : clock, asynchronous active-low reset
//   run/abort                 : start / stop pulses
//   clear, write_channel(_wrStrobe) : write buffer management (IDLE only)
//   read_channel(_rdStrobe)   : capture buffer readback (IDLE only)
//   clk_div, loop_count       : sample period minus 1, extra passes
//   output_signals/input_signals : pattern out, capture in
//   sample_count, write_buffer_len, next_read_sample, status : observability
// Build option: define AWG_EXT_TRIG_EN to add the ext_trig input; an
// accepted run then waits in WAIT_TRIG for a synchronised rising edge.
module awg_pattern_engine
  import awg_pkg::*;
#(
  parameter int unsigned NUM_SIG  = 8,
  parameter int unsigned NUM_SAMP = 256,
  parameter int unsigned DIV_W    = 16
) (
  input  logic                    axi_clk,
  input  logic                    axi_resetn,
`ifdef AWG_EXT_TRIG_EN
  input  logic                    ext_trig,
`endif
  input  logic                    run,
  input  logic                    abort,
  input  logic                    clear,
  input  logic [DIV_W-1:0]        clk_div,
  input  logic [DIV_W-1:0]        loop_count,
  input  logic [NUM_SIG-1:0]      write_channel,
  input  logic                    write_channel_wrStrobe,
  input  logic                    read_channel_rdStrobe,
  output logic [NUM_SIG-1:0]      read_channel,
  output logic [NUM_SIG-1:0]      output_signals,
  input  logic [NUM_SIG-1:0]      input_signals,
  output logic [SAMPLE_CNT_W-1:0] sample_count,
  output logic [31:0]             write_buffer_len,
  output logic [31:0]             next_read_sample,
  output logic [5:0]              status
);

  localparam int unsigned PTR_W = (NUM_SAMP > 1) ? $clog2(NUM_SAMP) : 1;
  localparam int unsigned LEN_W = $clog2(NUM_SAMP + 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(NUM_SAMP);

  awg_state_e state_q, state_d;

  logic [NUM_SIG-1:0]      wb_q [NUM_SAMP];
  logic [NUM_SIG-1:0]      rb_q [NUM_SAMP];
  logic [PTR_W-1:0]        wave_ptr_q;
  logic [DIV_W-1:0]        loop_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        rd_ptr_q;
  logic [SAMPLE_CNT_W-1:0] sample_cnt_q;
  logic [NUM_SIG-1:0]      out_q;
  logic [NUM_SIG-1:0]      read_q;
  logic                    done_q, aborted_q, ovf_q;

  logic tick, div_clr;
  logic busy, in_idle, in_done, accept, run_tick, abort_hit, last_sample, wr_accept;
  logic trig_rise;

`ifdef AWG_EXT_TRIG_EN
  // [0],[1] synchronise; [2] is the previous synchronised value for edge detect
  logic [2:0] trig_q;
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) trig_q <= '0;
    else             trig_q <= {trig_q[1:0], ext_trig};
  end
  assign trig_rise = trig_q[1] && !trig_q[2];
`else
  assign trig_rise = 1'b0;
`endif

  awg_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk    (axi_clk),
    .resetn (axi_resetn),
    .clr    (div_clr),
    .div    (clk_div),
    .tick   (tick)
  );

  assign last_sample = (LEN_W'(wave_ptr_q) == (len_q - LEN_W'(1)));

  // State register
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef AWG_EXT_TRIG_EN
        if (accept) state_d = ST_WAIT_TRIG;
`else
        if (accept) state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (abort) state_d = ST_IDLE;
        else if (run_tick && last_sample && (loop_q == loop_count)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_WAIT_TRIG: begin
`ifdef AWG_EXT_TRIG_EN
        if (abort)          state_d = ST_IDLE;
        else if (trig_rise) state_d = ST_RUN;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    in_done   = (state_q == ST_DONE);
    busy      = !in_idle;
    accept    = in_idle && run && !abort && (len_q != '0);
    run_tick  = (state_q == ST_RUN) && tick && !abort;
    abort_hit = abort && ((state_q == ST_RUN) || (state_q == ST_WAIT_TRIG));
    wr_accept = in_idle && !clear && write_channel_wrStrobe && (len_q < FULL_LEN);
    div_clr   = accept || ((state_q == ST_WAIT_TRIG) && trig_rise && !abort);
  end

  // Playback control, counters and flags
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wave_ptr_q   <= '0;
      loop_q       <= '0;
      len_q        <= '0;
      rd_ptr_q     <= '0;
      sample_cnt_q <= '0;
      out_q        <= '0;
      read_q       <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (accept) begin
        wave_ptr_q   <= '0;
        loop_q       <= '0;
        sample_cnt_q <= '0;
        done_q       <= 1'b0;
        aborted_q    <= 1'b0;
      end
      if (run_tick) begin
        out_q <= wb_q[wave_ptr_q];
        if (sample_cnt_q != '1) sample_cnt_q <= sample_cnt_q + SAMPLE_CNT_W'(1);
        if (!last_sample) begin
          wave_ptr_q <= wave_ptr_q + PTR_W'(1);
        end else if (loop_q != loop_count) begin
          wave_ptr_q <= '0;
          loop_q     <= loop_q + DIV_W'(1);
        end
      end
      if (in_done) begin
        done_q   <= 1'b1;
        out_q    <= '0;
        rd_ptr_q <= '0;
      end
      if (abort_hit) begin
        out_q     <= '0;
        aborted_q <= 1'b1;
      end
      if (in_idle) begin
        if (clear) begin
          len_q <= '0;
          ovf_q <= 1'b0;
        end else if (write_channel_wrStrobe) begin
          if (len_q < FULL_LEN) len_q <= len_q + LEN_W'(1);
          else                  ovf_q <= 1'b1;
        end
        if (read_channel_rdStrobe) begin
          if (rd_ptr_q < len_q) begin
            read_q   <= rb_q[PTR_W'(rd_ptr_q)];
            rd_ptr_q <= rd_ptr_q + LEN_W'(1);
          end else begin
            read_q <= '0;
          end
        end
      end
    end
  end

  // Write (pattern) buffer
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      for (int unsigned i = 0; i < NUM_SAMP; i++) wb_q[i] <= '0;
    end else if (wr_accept) begin
      wb_q[PTR_W'(len_q)] <= write_channel;
    end
  end

  // Read (capture) buffer; every pass overwrites, so the final pass remains
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      for (int unsigned i = 0; i < NUM_SAMP; i++) rb_q[i] <= '0;
    end else if (run_tick) begin
      rb_q[wave_ptr_q] <= input_signals;
    end
  end

  assign output_signals   = out_q;
  assign read_channel     = read_q;
  assign sample_count     = sample_cnt_q;
  assign write_buffer_len = 32'(len_q);
  assign next_read_sample = 32'(rd_ptr_q);

  always_comb begin
    status               = '0;
    status[1:0]          = state_q;
    status[STAT_BUSY]    = busy;
    status[STAT_DONE]    = done_q;
    status[STAT_ABORTED] = aborted_q;
    status[STAT_OVF]     = ovf_q;
  end

endmodule

// File: tb/tb_awg_pattern_engine.sv
// Self-checking bench for awg_pattern_engine. The reference model predicts
// playback and capture from sample timing arithmetic: with period P=clk_div+1
// counted from the start edge, tick j lands on edge (j+1)*P and plays
// pattern[j % len].
module tb_awg_pattern_engine;
  import awg_pkg::*;

  localparam int NS    = 8;
  localparam int NSAMP = 32;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          run = 1'b0, abort = 1'b0, clear = 1'b0;
  logic [DW-1:0] clk_div = '0, loop_count = '0;
  logic [NS-1:0] wch = '0;
  logic          wr = 1'b0, rd = 1'b0;
  logic [NS-1:0] rch, outs;
  logic [NS-1:0] ins = '0;
  logic [31:0]   scnt, wlen, nrs;
  logic [5:0]    status;
`ifdef AWG_EXT_TRIG_EN
  logic          ext_trig = 1'b0;
  int            trig_hold = 2;
`endif

  always #5 clk = ~clk;

  awg_pattern_engine #(.NUM_SIG(NS), .NUM_SAMP(NSAMP), .DIV_W(DW)) dut (
    .axi_clk                (clk),
    .axi_resetn             (rstn),
`ifdef AWG_EXT_TRIG_EN
    .ext_trig               (ext_trig),
`endif
    .run                    (run),
    .abort                  (abort),
    .clear                  (clear),
    .clk_div                (clk_div),
    .loop_count             (loop_count),
    .write_channel          (wch),
    .write_channel_wrStrobe (wr),
    .read_channel_rdStrobe  (rd),
    .read_channel           (rch),
    .output_signals         (outs),
    .input_signals          (ins),
    .sample_count           (scnt),
    .write_buffer_len       (wlen),
    .next_read_sample       (nrs),
    .status                 (status)
  );

  int checks = 0;
  int errors = 0;

  logic [NS-1:0] wb_m[$];
  bit            ovf_m;
  logic [NS-1:0] exp_rc;
  int            exp_rptr;
  logic [NS-1:0] inp_m [0:1023];
  logic [NS-1:0] rb_m  [0:NSAMP-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [NS-1:0] v);
    wch = v; wr = 1'b1; step(); wr = 1'b0;
    if (wb_m.size() < NSAMP) wb_m.push_back(v);
    else ovf_m = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
    wb_m.delete(); ovf_m = 1'b0;
  endtask

  // Accept a run; with the trigger option, hold ext_trig low then raise it.
  // Returns just after the edge that starts the divider (first RUN edge).
  task automatic start_run();
    run = 1'b1; step(); run = 1'b0;
`ifdef AWG_EXT_TRIG_EN
    checks++;
    if (status[1:0] !== 2'd3) begin
      errors++; $display("FAIL enter_wait_trig: state=%0d expected 3", status[1:0]);
    end
    for (int i = 0; i < trig_hold; i++) begin
      step();
      checks++;
      if (status[1:0] !== 2'd3 || outs !== '0) begin
        errors++; $display("FAIL wait_trig_hold: state=%0d out=%h expected state 3 out 00", status[1:0], outs);
      end
    end
    ext_trig = 1'b1;
    step(); step();
    if (status[1:0] !== 2'd1) step();
    checks++;
    if (status[1:0] !== 2'd1) begin
      errors++; $display("FAIL trig_to_run: state=%0d expected 1 within 3 cycles", status[1:0]);
    end
    ext_trig = 1'b0;
`else
    checks++;
    if (status[1:0] !== 2'd1) begin
      errors++; $display("FAIL run_accept: state=%0d expected 1", status[1:0]);
    end
`endif
  endtask

  task automatic run_check(input int div, input int loops, input bit rand_in);
    int len, P, N, T;
    logic [NS-1:0] exp_o;
    len = wb_m.size();
    P = div + 1;
    N = len * (loops + 1);
    T = N * P;
    clk_div = DW'(div);
    loop_count = DW'(loops);
    start_run();
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL out_at_start: got %h expected 00", outs);
    end
    for (int e = 1; e <= T + 1; e++) begin
      if (!rand_in && (e % P == 0) && e <= T) ins = NS'(((e / P) - 1) % len) ^ 8'hFF;
      else ins = NS'($urandom);
      inp_m[e] = ins;
      step();
      exp_o = (e >= P && e <= T) ? wb_m[((e / P) - 1) % len] : '0;
      checks++;
      if (outs !== exp_o) begin
        errors++; $display("FAIL playback e=%0d: got %h expected %h", e, outs, exp_o);
      end
      checks++;
      if (status[STAT_BUSY] !== (e <= T)) begin
        errors++; $display("FAIL busy e=%0d: got %b expected %b", e, status[STAT_BUSY], (e <= T));
      end
    end
    for (int p = 0; p < len; p++) rb_m[p] = inp_m[(loops * len + p + 1) * P];
    checks++;
    if (scnt !== 32'(N)) begin
      errors++; $display("FAIL sample_count: got %0d expected %0d", scnt, N);
    end
    checks++;
    if (status[STAT_DONE] !== 1'b1 || status[STAT_ABORTED] !== 1'b0 || status[1:0] !== 2'd0) begin
      errors++; $display("FAIL end_status: got %b expected done=1 aborted=0 idle", status);
    end
    checks++;
    if (nrs !== 32'd0) begin
      errors++; $display("FAIL rdptr_after_done: got %0d expected 0", nrs);
    end
    exp_rptr = 0;
    for (int p = 0; p <= len; p++) begin
      rd = 1'b1; step(); rd = 1'b0;
      if (exp_rptr < len) begin
        exp_rc = rb_m[exp_rptr]; exp_rptr++;
      end else begin
        exp_rc = '0;
      end
      checks++;
      if (rch !== exp_rc || nrs !== 32'(exp_rptr)) begin
        errors++; $display("FAIL readback p=%0d: got %h ptr %0d expected %h ptr %0d", p, rch, nrs, exp_rc, exp_rptr);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(); step();
    checks++;
    if (outs !== '0 || rch !== '0 || scnt !== '0 || wlen !== '0 || nrs !== '0 || status !== '0) begin
      errors++; $display("FAIL reset_values: out=%h rd=%h cnt=%0d len=%0d ptr=%0d st=%b expected all 0", outs, rch, scnt, wlen, nrs, status);
    end
    @(negedge clk); rstn = 1'b1;
    step();
    checks++;
    if (status !== '0 || outs !== '0) begin
      errors++; $display("FAIL after_reset: st=%b out=%h expected 0", status, outs);
    end
    wb_m.delete(); ovf_m = 1'b0; exp_rc = '0; exp_rptr = 0;
  endtask

  task automatic test_basic();
    do_clear();
    load(8'h01); load(8'h02); load(8'h04); load(8'h08);
    checks++;
    if (wlen !== 32'd4) begin
      errors++; $display("FAIL load_len: got %0d expected 4", wlen);
    end
    run_check(0, 0, 1'b0);
  endtask

  task automatic test_div_loop();
    run_check(2, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int n;
      do_clear();
      n = int'($urandom_range(1, 10));
      for (int i = 0; i < n; i++) load(NS'($urandom));
      run_check(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1);
    end
  endtask

  task automatic test_abort();
    do_clear();
    for (int i = 0; i < 4; i++) load(NS'($urandom) | 8'h01);
    clk_div = '0; loop_count = '0;
    start_run();
    wch = NS'($urandom); wr = 1'b1; run = 1'b1; rd = 1'b1;
    step();
    wr = 1'b0; run = 1'b0; rd = 1'b0;
    checks++;
    if (outs !== wb_m[0] || rch !== exp_rc || nrs !== 32'(exp_rptr)) begin
      errors++; $display("FAIL busy_ignore: out=%h rd=%h ptr=%0d expected %h %h %0d", outs, rch, nrs, wb_m[0], exp_rc, exp_rptr);
    end
    step();
    checks++;
    if (outs !== wb_m[1]) begin
      errors++; $display("FAIL abort_pre: got %h expected %h", outs, wb_m[1]);
    end
    abort = 1'b1; run = 1'b1; step(); abort = 1'b0; run = 1'b0;
    checks++;
    if (status[1:0] !== 2'd0 || outs !== '0 || status[STAT_ABORTED] !== 1'b1 || status[STAT_DONE] !== 1'b0) begin
      errors++; $display("FAIL abort_state: st=%b out=%h expected idle aborted=1 done=0 out 00", status, outs);
    end
    checks++;
    if (scnt !== 32'd2 || wlen !== 32'd4) begin
      errors++; $display("FAIL abort_counts: cnt=%0d len=%0d expected 2 and 4", scnt, wlen);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < NSAMP + 1; i++) load(NS'($urandom));
    checks++;
    if (wlen !== 32'(NSAMP) || status[STAT_OVF] !== ovf_m) begin
      errors++; $display("FAIL overflow: len=%0d ovf=%b expected %0d 1", wlen, status[STAT_OVF], NSAMP);
    end
    clear = 1'b1; wr = 1'b1; step(); clear = 1'b0; wr = 1'b0;
    wb_m.delete(); ovf_m = 1'b0;
    checks++;
    if (wlen !== 32'd0 || status[STAT_OVF] !== 1'b0) begin
      errors++; $display("FAIL clear: len=%0d ovf=%b expected 0 0", wlen, status[STAT_OVF]);
    end
    run = 1'b1; step(); run = 1'b0;
    checks++;
    if (status[1:0] !== 2'd0) begin
      errors++; $display("FAIL empty_run: state=%0d expected 0", status[1:0]);
    end
    rd = 1'b1; step(); rd = 1'b0;
    exp_rc = '0;
    checks++;
    if (rch !== exp_rc || nrs !== 32'(exp_rptr)) begin
      errors++; $display("FAIL empty_read: rd=%h ptr=%0d expected 00 %0d", rch, nrs, exp_rptr);
    end
  endtask

`ifdef AWG_EXT_TRIG_EN
  task automatic test_ext_trig();
    do_clear();
    load(NS'($urandom)); load(NS'($urandom));
    trig_hold = 20;
    run_check(0, 0, 1'b1);
    trig_hold = 2;
    run = 1'b1; step(); run = 1'b0;
    step();
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (status[1:0] !== 2'd0 || status[STAT_ABORTED] !== 1'b1 || status[STAT_DONE] !== 1'b0) begin
      errors++; $display("FAIL abort_wait_trig: st=%b expected idle aborted=1 done=0", status);
    end
  endtask
`endif

  task automatic test_reset_midrun();
    do_clear();
    for (int i = 0; i < 3; i++) load(NS'($urandom) | 8'h01);
    clk_div = DW'(1); loop_count = '0;
    start_run();
    step(); step(); step();
    checks++;
    if (outs !== wb_m[0]) begin
      errors++; $display("FAIL midrun_out: got %h expected %h", outs, wb_m[0]);
    end
    #2; rstn = 1'b0; #1;
    checks++;
    if (outs !== '0 || status !== '0 || scnt !== '0 || wlen !== '0) begin
      errors++; $display("FAIL async_reset: out=%h st=%b cnt=%0d len=%0d expected all 0", outs, status, scnt, wlen);
    end
    @(negedge clk); rstn = 1'b1;
    wb_m.delete(); ovf_m = 1'b0; exp_rc = '0; exp_rptr = 0;
    step();
    checks++;
    if (status !== '0) begin
      errors++; $display("FAIL no_done_after_reset: st=%b expected 0", status);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_div_loop();
    test_random();
    test_abort();
    test_overflow();
`ifdef AWG_EXT_TRIG_EN
    test_ext_trig();
`endif
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
